// File: rtl/reg_file_mp_if.sv
// Bundle of decode/writeback/store-side signals of the multi-port integer register file.
// Master drives addresses, write and scoreboard requests; slave returns read, busy and store data.
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wa_we;
    logic [AW-1:0]       wa_addr;
    logic [XLEN-1:0]     wa_data;
    logic                wb_we;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                busy_set;
    logic [AW-1:0]       busy_addr;
    logic                st_req;
    logic [AW-1:0]       st_addr;
    logic [XLEN-1:0]     st_data;
    logic                st_valid;

    modport master (
        output rd_addr, wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data,
               busy_set, busy_addr, st_req, st_addr,
        input  rd_data, rd_busy, st_data, st_valid
    );

    modport slave (
        input  rd_addr, wa_we, wa_addr, wa_data, wb_we, wb_addr, wb_data,
               busy_set, busy_addr, st_req, st_addr,
        output rd_data, rd_busy, st_data, st_valid
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational bypassed reads, two write ports (B wins), load scoreboard.
// Store readout has 1-cycle latency; no backpressure, every request is served the cycle it arrives.
module reg_file_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int ZERO_REG  = 1,
    parameter int RESET_IDX = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    reg_file_mp_if.slave rf
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  st_data_q;
    logic             st_valid_q;

    logic             wa_ok, wb_ok, bs_ok;
    logic [AW-1:0]    rq_addr [NRD+1];
    logic [XLEN-1:0]  rd_val  [NRD+1];

    // Hard-wired zero register and the unused tail of the address space are not storage.
    function automatic logic legal(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wa_ok = rf.wa_we    && legal(rf.wa_addr);
    assign wb_ok = rf.wb_we    && legal(rf.wb_addr);
    assign bs_ok = rf.busy_set && legal(rf.busy_addr);

    // Slot NRD is the store port; it shares the bypass path with the decode ports.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rq_addr[k] = rf.rd_addr[k*AW +: AW];
        end
        rq_addr[NRD] = rf.st_addr;
    end

    always_comb begin
        for (int k = 0; k <= NRD; k++) begin
            rd_val[k] = '0;
            if (legal(rq_addr[k])) begin
                if (wb_ok && (rf.wb_addr == rq_addr[k])) begin
                    rd_val[k] = rf.wb_data;
                end else if (wa_ok && (rf.wa_addr == rq_addr[k])) begin
                    rd_val[k] = rf.wa_data;
                end else begin
                    rd_val[k] = regs_q[rq_addr[k]];
                end
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign rf.rd_data[k*XLEN +: XLEN] = rd_val[k];
        assign rf.rd_busy[k] = legal(rq_addr[k]) && busy_q[rq_addr[k]]
                               && !(rf.wb_we && (rf.wb_addr == rq_addr[k]));
    end

    // A load issued on the same register its previous load returns to stays pending.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wb_ok && (rf.wb_addr == AW'(i))) busy_d[i] = 1'b0;
            if (bs_ok && (rf.busy_addr == AW'(i))) busy_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (RESET_IDX != 0) ? XLEN'(i) : '0;
            end
            busy_q     <= '0;
            st_data_q  <= '0;
            st_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wb_ok && (rf.wb_addr == AW'(i))) begin
                    regs_q[i] <= rf.wb_data;
                end else if (wa_ok && (rf.wa_addr == AW'(i))) begin
                    regs_q[i] <= rf.wa_data;
                end
            end
            busy_q     <= busy_d;
            st_valid_q <= rf.st_req;
            if (rf.st_req) st_data_q <= rd_val[NRD];
        end
    end

    assign rf.st_data  = st_data_q;
    assign rf.st_valid = st_valid_q;
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: vector table on the default build, hand sequences for async reset
// and a ZERO_REG=0 / NREGS=24 build exercising illegal addresses.
module tb_reg_file_mp;
    logic clk;
    logic rst_n;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) if0 ();
    reg_file_mp_if #(.XLEN(32), .NREGS(24), .NRD(2)) if1 ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .RESET_IDX(1)) u_dut0 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .rf    (if0)
    );

    reg_file_mp #(.XLEN(32), .NREGS(24), .NRD(2), .ZERO_REG(0), .RESET_IDX(1)) u_dut1 (
        .clk_i (clk),
        .rst_ni(rst_n),
        .rf    (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wa_we;
        logic [4:0]  wa_addr;
        logic [31:0] wa_data;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        bs;
        logic [4:0]  bs_addr;
        logic        st_req;
        logic [4:0]  st_addr;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [1:0]  exp_busy;
        logic [31:0] exp_st;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] st_q[$];
    logic [31:0] st_hold = 32'h0;
    vec_t        vecs[16];

    function automatic vec_t mk(input int wa_we, input int wa_addr, input logic [31:0] wa_data,
                                input int wb_we, input int wb_addr, input logic [31:0] wb_data,
                                input int bs, input int bs_addr, input int st_req, input int st_addr,
                                input int ra0, input int ra1, input logic [31:0] exp0,
                                input logic [31:0] exp1, input int exp_busy, input logic [31:0] exp_st);
        vec_t v;
        v.wa_we = 1'(wa_we);   v.wa_addr = 5'(wa_addr); v.wa_data = wa_data;
        v.wb_we = 1'(wb_we);   v.wb_addr = 5'(wb_addr); v.wb_data = wb_data;
        v.bs = 1'(bs);         v.bs_addr = 5'(bs_addr);
        v.st_req = 1'(st_req); v.st_addr = 5'(st_addr);
        v.ra0 = 5'(ra0);       v.ra1 = 5'(ra1);
        v.exp0 = exp0;         v.exp1 = exp1;
        v.exp_busy = 2'(exp_busy); v.exp_st = exp_st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle0();
        if0.wa_we = 1'b0; if0.wa_addr = '0; if0.wa_data = '0;
        if0.wb_we = 1'b0; if0.wb_addr = '0; if0.wb_data = '0;
        if0.busy_set = 1'b0; if0.busy_addr = '0;
        if0.st_req = 1'b0; if0.st_addr = '0;
    endtask

    task automatic idle1();
        if1.rd_addr = '0;
        if1.wa_we = 1'b0; if1.wa_addr = '0; if1.wa_data = '0;
        if1.wb_we = 1'b0; if1.wb_addr = '0; if1.wb_data = '0;
        if1.busy_set = 1'b0; if1.busy_addr = '0;
        if1.st_req = 1'b0; if1.st_addr = '0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_d;
        if0.wa_we = v.wa_we; if0.wa_addr = v.wa_addr; if0.wa_data = v.wa_data;
        if0.wb_we = v.wb_we; if0.wb_addr = v.wb_addr; if0.wb_data = v.wb_data;
        if0.busy_set = v.bs; if0.busy_addr = v.bs_addr;
        if0.st_req = v.st_req; if0.st_addr = v.st_addr;
        if0.rd_addr = {v.ra1, v.ra0};
        #4;
        check($sformatf("v%0d rd0", idx), if0.rd_data[31:0], v.exp0);
        check($sformatf("v%0d rd1", idx), if0.rd_data[63:32], v.exp1);
        check($sformatf("v%0d busy", idx), {30'b0, if0.rd_busy}, {30'b0, v.exp_busy});
        if (v.st_req) st_q.push_back(v.exp_st);
        @(posedge clk);
        #1;
        check($sformatf("v%0d st_valid", idx), {31'b0, if0.st_valid}, {31'b0, v.st_req});
        if (v.st_req) begin
            if (st_q.size() == 0) begin
                total++; bad++;
                $display("FAIL v%0d st_queue: got empty expected entry", idx);
                exp_d = st_hold;
            end else begin
                exp_d = st_q.pop_front();
            end
            st_hold = exp_d;
        end else begin
            exp_d = st_hold;
        end
        check($sformatf("v%0d st_data", idx), if0.st_data, exp_d);
    endtask

    initial begin
        //            waW wa  waD           wbW wb  wbD           bs bsA st stA r0  r1  e0            e1            busy eSt
        vecs[0]  = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  5,  31, 5,            31,           0,   0);
        vecs[1]  = mk(1,  3,  32'hAAAA5555, 1,  3,  32'h12345678, 0, 0,  0, 0,  3,  0,  32'h12345678, 0,            0,   0);
        vecs[2]  = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  3,  2,  32'h12345678, 2,            0,   0);
        vecs[3]  = mk(1,  0,  32'hFFFFFFFF, 0,  0,  0,            0, 0,  0, 0,  0,  1,  0,            1,            0,   0);
        vecs[4]  = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  0,  3,  0,            32'h12345678, 0,   0);
        vecs[5]  = mk(0,  0,  0,            0,  0,  0,            1, 7,  0, 0,  7,  9,  7,            9,            0,   0);
        vecs[6]  = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  7,  9,  7,            9,            1,   0);
        vecs[7]  = mk(0,  0,  0,            1,  7,  32'h77,       0, 0,  0, 0,  7,  9,  32'h77,       9,            0,   0);
        vecs[8]  = mk(0,  0,  0,            1,  9,  32'h99,       1, 9,  0, 0,  7,  9,  32'h77,       32'h99,       0,   0);
        vecs[9]  = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  9,  7,  32'h99,       32'h77,       1,   0);
        vecs[10] = mk(1,  9,  32'h1,        0,  0,  0,            0, 0,  0, 0,  9,  9,  1,            1,            3,   0);
        vecs[11] = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  9,  3,  1,            32'h12345678, 1,   0);
        vecs[12] = mk(1,  4,  32'hDEAD,     0,  0,  0,            0, 0,  1, 4,  4,  5,  32'hDEAD,     5,            0,   32'hDEAD);
        vecs[13] = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  4,  0,  32'hDEAD,     0,            0,   0);
        vecs[14] = mk(0,  0,  0,            0,  0,  0,            1, 0,  1, 5,  0,  5,  0,            5,            0,   5);
        vecs[15] = mk(0,  0,  0,            0,  0,  0,            0, 0,  0, 0,  0,  9,  0,            1,            2,   0);

        rst_n = 1'b0;
        idle0();
        idle1();
        if0.rd_addr = {5'd31, 5'd5};
        #12;
        check("rst rd5", if0.rd_data[31:0], 32'h5);
        check("rst rd31", if0.rd_data[63:32], 32'h1F);
        check("rst busy", {30'b0, if0.rd_busy}, 32'h0);
        check("rst st_valid", {31'b0, if0.st_valid}, 32'h0);
        check("rst st_data", if0.st_data, 32'h0);
        if0.rd_addr = {5'd0, 5'd0};
        #1;
        check("rst reg0", if0.rd_data[31:0], 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Asynchronous reset in the middle of traffic
        idle0();
        if0.busy_set = 1'b1; if0.busy_addr = 5'd11;
        if0.st_req = 1'b1;   if0.st_addr = 5'd6;
        @(posedge clk);
        #1;
        idle0();
        if0.rd_addr = {5'd11, 5'd9};
        #1;
        check("pre-rst busy", {30'b0, if0.rd_busy}, 32'h3);
        check("pre-rst st_valid", {31'b0, if0.st_valid}, 32'h1);
        check("pre-rst st_data", if0.st_data, 32'h6);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst busy", {30'b0, if0.rd_busy}, 32'h0);
        check("arst st_valid", {31'b0, if0.st_valid}, 32'h0);
        check("arst st_data", if0.st_data, 32'h0);
        check("arst rd9", if0.rd_data[31:0], 32'h9);
        check("arst rd11", if0.rd_data[63:32], 32'hB);
        if0.rd_addr = {5'd4, 5'd3};
        #1;
        check("arst rd3", if0.rd_data[31:0], 32'h3);
        check("arst rd4", if0.rd_data[63:32], 32'h4);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Build with ZERO_REG=0 and NREGS=24: reg0 is ordinary, addresses 24..31 illegal
        if1.rd_addr = {5'd30, 5'd23};
        #1;
        check("z0 rd23", if1.rd_data[31:0], 32'd23);
        check("z0 rd30", if1.rd_data[63:32], 32'h0);
        if1.wa_we = 1'b1; if1.wa_addr = 5'd0; if1.wa_data = 32'hFFFFFFFF;
        if1.busy_set = 1'b1; if1.busy_addr = 5'd30;
        if1.rd_addr = {5'd30, 5'd0};
        #1;
        check("z0 bypass reg0", if1.rd_data[31:0], 32'hFFFFFFFF);
        @(posedge clk);
        #1;
        if1.wa_we = 1'b1; if1.wa_addr = 5'd30; if1.wa_data = 32'h55;
        if1.busy_set = 1'b1; if1.busy_addr = 5'd0;
        if1.st_req = 1'b1; if1.st_addr = 5'd0;
        st_q.push_back(32'hFFFFFFFF);
        #1;
        check("z0 reg0 stored", if1.rd_data[31:0], 32'hFFFFFFFF);
        check("z0 illegal bypass", if1.rd_data[63:32], 32'h0);
        check("z0 illegal busy", {30'b0, if1.rd_busy}, 32'h0);
        @(posedge clk);
        #1;
        idle1();
        if1.rd_addr = {5'd30, 5'd0};
        #1;
        check("z0 reg0 busy", {30'b0, if1.rd_busy}, 32'h1);
        check("z0 illegal write dropped", if1.rd_data[63:32], 32'h0);
        check("z0 st_valid", {31'b0, if1.st_valid}, 32'h1);
        if (st_q.size() == 0) begin
            total++; bad++;
            $display("FAIL z0 st_queue: got empty expected entry");
        end else begin
            check("z0 st_data", if1.st_data, st_q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
